// File: rtl/rb_read_scheduler.sv
// Read-side scheduler for a ring of row buffers: tracks buffer occupancy and
// sweeps KROWS parallel taps across one pass of RB_DEPTH locations.
module rb_read_scheduler #(
    parameter int RBS      = 4,
    parameter int RB_DEPTH = 512,
    parameter int BRAMS    = 1,
    parameter int KROWS    = 3,
    localparam int LW = $clog2(RB_DEPTH),
    localparam int AW = LW + 2,
    localparam int BW = (BRAMS > 1) ? $clog2(BRAMS) : 1,
    localparam int PW = (RBS > 1) ? $clog2(RBS) : 1,
    localparam int FW = $clog2(RBS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                row_done,
    input  logic                out_ready,
    output logic                win_valid,
    output logic [KROWS*BW-1:0] rd_bram,
    output logic [KROWS*AW-1:0] rd_addr,
    output logic [LW-1:0]       col,
    output logic                row_last,
    output logic [FW-1:0]       filled,
    output logic                overflow
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    typedef logic [PW:0] buf_t;

    localparam logic [LW-1:0] COL_LAST   = LW'(RB_DEPTH - 1);
    localparam logic [FW-1:0] FILL_MAX   = FW'(RBS);
    localparam logic [FW-1:0] FILL_START = FW'(KROWS);
    localparam logic [PW-1:0] TOP_LAST   = PW'(RBS - 1);

    state_t                state_q, state_d;
    logic [PW-1:0]         top_q, top_d;
    logic [LW-1:0]         col_q, col_d;
    logic [FW-1:0]         filled_q, filled_d;
    logic                  overflow_q, overflow_d;
    logic                  win_valid_q, win_valid_d;
    logic                  row_last_q, row_last_d;
    logic [KROWS*BW-1:0]   rd_bram_q, rd_bram_d;
    logic [KROWS*AW-1:0]   rd_addr_q, rd_addr_d;
    logic                  handshake_s;
    logic                  pass_end_s;
    buf_t                  tap_buf_s;

    // (top + k) mod RBS; top < RBS and k < RBS so one subtract suffices
    function automatic buf_t tap_buf(input logic [PW-1:0] top, input int k);
        buf_t sum;
        sum = {1'b0, top} + buf_t'(k);
        if (sum >= buf_t'(RBS)) begin
            sum = sum - buf_t'(RBS);
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

    // Occupancy bookkeeping, pass sequencing and next tap addresses
    always_comb begin
        state_d     = state_q;
        top_d       = top_q;
        col_d       = col_q;
        filled_d    = filled_q;
        overflow_d  = overflow_q;
        win_valid_d = win_valid_q;
        rd_bram_d   = '0;
        rd_addr_d   = '0;
        tap_buf_s   = '0;
        handshake_s = win_valid_q && out_ready;
        pass_end_s  = handshake_s && (col_q == COL_LAST);

        // A write completing on the release edge cancels out the release
        if (row_done) begin
            if (filled_q == FILL_MAX) begin
                overflow_d = 1'b1;
            end else if (!pass_end_s) begin
                filled_d = filled_q + FW'(1);
            end else begin
                filled_d = filled_q;
            end
        end else if (pass_end_s) begin
            filled_d = filled_q - FW'(1);
        end else begin
            filled_d = filled_q;
        end

        case (state_q)
            IDLE: begin
                if (filled_q >= FILL_START) begin
                    state_d     = RUN;
                    col_d       = '0;
                    win_valid_d = 1'b1;
                end else begin
                    state_d     = IDLE;
                    win_valid_d = 1'b0;
                end
            end
            RUN: begin
                if (pass_end_s) begin
                    state_d     = IDLE;
                    col_d       = '0;
                    win_valid_d = 1'b0;
                    top_d       = (top_q == TOP_LAST) ? '0 : top_q + PW'(1);
                end else if (handshake_s) begin
                    col_d = col_q + LW'(1);
                end else begin
                    col_d = col_q;
                end
            end
            default: begin
                state_d     = IDLE;
                win_valid_d = 1'b0;
            end
        endcase

        row_last_d = win_valid_d && (col_d == COL_LAST);

        for (int k = 0; k < KROWS; k++) begin
            tap_buf_s = tap_buf(top_d, k);
            rd_bram_d[k*BW +: BW] = BW'(tap_buf_s >> 2);
            rd_addr_d[k*AW +: AW] = {col_d, tap_buf_s[1:0]};
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            top_q       <= '0;
            col_q       <= '0;
            filled_q    <= '0;
            overflow_q  <= 1'b0;
            win_valid_q <= 1'b0;
            row_last_q  <= 1'b0;
            rd_bram_q   <= '0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            top_q       <= top_d;
            col_q       <= col_d;
            filled_q    <= filled_d;
            overflow_q  <= overflow_d;
            win_valid_q <= win_valid_d;
            row_last_q  <= row_last_d;
            rd_bram_q   <= rd_bram_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign win_valid = win_valid_q;
    assign rd_bram   = rd_bram_q;
    assign rd_addr   = rd_addr_q;
    assign col       = col_q;
    assign row_last  = row_last_q;
    assign filled    = filled_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_rb_read_scheduler.sv
// Bench for rb_read_scheduler (RBS=4, RB_DEPTH=8, KROWS=3): occupancy/pass
// model checked every cycle, plus directed literal checks.
module tb_rb_read_scheduler;

    localparam int RBS = 4, DEPTH = 8, BRAMS = 1, KROWS = 3;
    localparam int LW = 3, AW = 5, BW = 1, FW = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                row_done;
    logic                out_ready;
    logic                win_valid;
    logic [KROWS*BW-1:0] rd_bram;
    logic [KROWS*AW-1:0] rd_addr;
    logic [LW-1:0]       col;
    logic                row_last;
    logic [FW-1:0]       filled;
    logic                overflow;

    int total = 0;
    int bad   = 0;

    rb_read_scheduler #(.RBS(RBS), .RB_DEPTH(DEPTH), .BRAMS(BRAMS), .KROWS(KROWS)) dut (
        .clk(clk), .rst(rst), .row_done(row_done), .out_ready(out_ready),
        .win_valid(win_valid), .rd_bram(rd_bram), .rd_addr(rd_addr), .col(col),
        .row_last(row_last), .filled(filled), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: occupancy count, ring head and position within a pass
    bit m_run, m_ovf;
    int m_top, m_col, m_filled;
    int nf;
    bit m_hs, m_last;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 0; m_ovf <= 0; m_top <= 0; m_col <= 0; m_filled <= 0;
        end else begin
            m_hs   = m_run && out_ready;
            m_last = m_hs && (m_col == DEPTH - 1);
            nf     = m_filled;
            if (row_done) begin
                if (m_filled == RBS) m_ovf <= 1;
                else if (!m_last) nf = m_filled + 1;
            end else if (m_last) begin
                nf = m_filled - 1;
            end
            if (!m_run) begin
                if (m_filled >= KROWS) begin m_run <= 1; m_col <= 0; end
            end else if (m_last) begin
                m_run <= 0; m_col <= 0; m_top <= (m_top + 1) % RBS;
            end else if (m_hs) begin
                m_col <= m_col + 1;
            end
            m_filled <= nf;
        end
    end

    // Compare every output against the model once per cycle
    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_win_valid", win_valid, m_run);
            check("cmp_col", col, m_col);
            check("cmp_filled", filled, m_filled);
            check("cmp_overflow", overflow, m_ovf);
            check("cmp_row_last", row_last, m_run && (m_col == DEPTH - 1));
            if (m_run) begin
                for (int k = 0; k < KROWS; k++) begin
                    check("cmp_tap_addr", rd_addr[k*AW +: AW], ((m_top + k) % RBS) % 4 + m_col * 4);
                    check("cmp_tap_bram", rd_bram[k*BW +: BW], ((m_top + k) % RBS) / 4);
                end
            end
        end
    end

    task automatic pulse_row();
        @(negedge clk); row_done = 1'b1;
        @(negedge clk); row_done = 1'b0;
    endtask

    task automatic wait_col(input int target);
        int n = 0;
        while (!(win_valid && col == LW'(target)) && n < 40) begin
            @(negedge clk); n++;
        end
        check("wait_col_bound", (win_valid && col == LW'(target)), 1);
    endtask

    task automatic run_to_end();
        int n = 0;
        while (win_valid && n < 40) begin
            @(negedge clk); n++;
        end
        check("run_end_bound", win_valid, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wv"}, win_valid, 0);
        check({tag, "_col"}, col, 0);
        check({tag, "_filled"}, filled, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_rlast"}, row_last, 0);
        check({tag, "_addr"}, rd_addr, 0);
        check({tag, "_bram"}, rd_bram, 0);
    endtask

    logic [3:0] pat = 4'b1001;
    int hs_cnt;
    logic prev_ready;
    logic [LW-1:0] prev_col;
    logic [KROWS*AW-1:0] prev_addr;

    initial begin
        rst = 1'b1; row_done = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Pass 1: buffers {0,1,2}
        pulse_row(); pulse_row(); pulse_row();
        check("p1_filled3", filled, 3);
        check("p1_wv_latency", win_valid, 0);
        @(negedge clk);
        check("p1_wv", win_valid, 1);
        check("p1_col0", col, 0);
        check("p1_addr_col0", rd_addr, 15'd2080);
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            check("p1_col_step", col, i);
        end
        check("p1_addr_col7", rd_addr, 15'd31676);
        check("p1_row_last", row_last, 1);
        @(negedge clk);
        check("p1_done_wv", win_valid, 0);
        check("p1_done_filled", filled, 2);

        // Pass 2: buffers {1,2,3} with a stalling consumer
        pulse_row();
        @(negedge clk);
        check("p2_wv", win_valid, 1);
        check("p2_addr_col0", rd_addr, 15'd3137);
        hs_cnt = 0;
        for (int c = 0; c < 100 && win_valid; c++) begin
            out_ready = pat[c % 4];
            if (out_ready) hs_cnt++;
            prev_ready = out_ready; prev_col = col; prev_addr = rd_addr;
            @(negedge clk);
            if (!prev_ready) begin
                check("p2_freeze_col", col, prev_col);
                check("p2_freeze_addr", rd_addr, prev_addr);
                check("p2_freeze_wv", win_valid, 1);
            end
        end
        check("p2_handshakes", hs_cnt, 8);
        check("p2_done_wv", win_valid, 0);
        out_ready = 1'b1;

        // Pass 3: ring wraps, buffers {2,3,0}
        pulse_row();
        @(negedge clk);
        check("p3_wv", win_valid, 1);
        check("p3_addr_col0", rd_addr, 15'd98);
        run_to_end();
        check("p3_filled", filled, 2);

        // row_done on the final handshake with filled=3
        pulse_row();
        @(negedge clk);
        wait_col(7);
        check("coin_row_last", row_last, 1);
        row_done = 1'b1;
        @(negedge clk);
        row_done = 1'b0;
        check("coin_wv_low", win_valid, 0);
        check("coin_filled", filled, 3);
        check("coin_ovf", overflow, 0);
        @(negedge clk);
        check("coin_next_wv", win_valid, 1);
        check("coin_next_addr", rd_addr, 15'd2080);
        run_to_end();

        // Asynchronous reset in the middle of a pass
        pulse_row();
        @(negedge clk);
        wait_col(4);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        pulse_row(); pulse_row();
        repeat (3) @(negedge clk);
        check("post_rst_wv", win_valid, 0);
        check("post_rst_filled", filled, 2);
        pulse_row();
        check("post_rst_wv3", win_valid, 0);
        @(negedge clk);
        check("post_rst_pass", win_valid, 1);
        check("post_rst_addr", rd_addr, 15'd2080);
        run_to_end();

        // Overflow: five writes while the consumer never accepts
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; out_ready = 1'b0;
        repeat (5) pulse_row();
        check("ovf_filled", filled, 4);
        check("ovf_flag", overflow, 1);
        repeat (3) @(negedge clk);
        check("ovf_sticky", overflow, 1);
        check("ovf_filled_hold", filled, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rb_read_scheduler.md
RB_READ_SCHEDULER -- requirements
Module: rb_read_scheduler

Interface
REQ-001 SHALL have parameter RBS, default 4, meaning the number of row buffers, with legal range KROWS..16.
REQ-002 SHALL have parameter RB_DEPTH, default 512, meaning the number of pixel locations per row buffer, which is a power of 2.
REQ-003 SHALL have parameter BRAMS, default 1, meaning the number of BRAMs, equal to ceil(RBS/4).
REQ-004 SHALL have parameter KROWS, default 3, meaning the number of window rows read in parallel.
REQ-005 SHALL derive widths: LW=clog2(RB_DEPTH); AW=LW+2; BW=max(1,clog2(BRAMS)); PW=max(1,clog2(RBS)); FW=clog2(RBS+1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port row_done, input, 1 bit: a one-cycle pulse from the write side meaning one complete row buffer has been written.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the current tap set.
REQ-010 SHALL have port win_valid, output, 1 bit: the tap outputs are valid.
REQ-011 SHALL have port rd_bram, output, KROWS*BW bits: the packed BRAM select per tap, with tap k at bits [k*BW +: BW].
REQ-012 SHALL have port rd_addr, output, KROWS*AW bits: the packed BRAM depth address per tap, with tap k at bits [k*AW +: AW].
REQ-013 SHALL have port col, output, LW bits: the current location index.
REQ-014 SHALL have port row_last, output, 1 bit: high together with win_valid when col==RB_DEPTH-1.
REQ-015 SHALL have port filled, output, FW bits: the number of written, unreleased row buffers.
REQ-016 SHALL have port overflow, output, 1 bit: a sticky error flag.

Function
REQ-017 SHALL implement an FSM with states IDLE and RUN, and SHALL register all outputs.
REQ-018 SHALL, in IDLE, with filled>=KROWS, enter RUN on the next edge with col=0 and win_valid=1 on that same edge, giving one cycle of latency from the condition.
REQ-019 SHALL hold win_valid=1 throughout RUN; a handshake is win_valid&&out_ready.
REQ-020 SHALL, when win_valid&&!out_ready, hold every output stable.
REQ-021 SHALL, on a handshake with col<RB_DEPTH-1, increment col by exactly 1, with no bubble.
REQ-022 SHALL, on a handshake with col==RB_DEPTH-1, wrap col to 0, deassert win_valid, return to IDLE, advance top=(top+1) mod RBS, and decrement filled by 1.
REQ-023 SHALL compute, per tap k: buffer b=(top+k) mod RBS; rd_bram=b>>2; rd_addr=(b&3)+(col<<2).
REQ-024 SHALL implement mod RBS by compare-and-subtract; RBS need not be a power of 2.
REQ-025 SHALL, on row_done with filled<RBS, increment filled.
REQ-026 SHALL, on row_done with filled==RBS, leave filled unchanged and set overflow=1, which stays set until reset.
REQ-027 SHALL, when row_done coincides with the final handshake of a pass, leave filled unchanged, or set overflow if filled was RBS before the edge; the pass still completes.
REQ-028 SHALL evaluate IDLE->RUN on the filled value after any update, so back-to-back passes have exactly one IDLE cycle between them.
REQ-029 SHALL keep filled within 0..RBS at all times.

Reset
REQ-030 SHALL, while rst=1, immediately force state=IDLE, top=0, col=0, filled=0, win_valid=0, row_last=0, overflow=0, rd_bram=0, rd_addr=0.
REQ-031 SHALL, on rst asserted mid-pass, abort the pass; the first pass after reset again requires KROWS row_done pulses.
REQ-032 SHALL begin normal operation on the first clk edge after rst deasserts.

Verification (RBS=4, RB_DEPTH=8, KROWS=3, BRAMS=1)
REQ-033 SHALL check: 3 row_done pulses, out_ready=1 -> win_valid 1 cycle after filled==3; 8 beats with col 0..7; tap addresses {0,1,2},{4,5,6}...{28,29,30}; then filled=2, top=1.
REQ-034 SHALL check: a second pass after a 4th row_done -> taps use buffers {1,2,3}, addresses at col 0 = {1,2,3}; third pass buffers {2,3,0}, addresses at col 0 = {2,3,0}.
REQ-035 SHALL check: out_ready toggling 1,0,0,1 -> outputs frozen during the low cycles; exactly 8 handshakes per pass.
REQ-036 SHALL check: 5 row_done pulses with no pass -> filled=4, overflow=1.
REQ-037 SHALL check: row_done on the final handshake with filled=3 -> filled stays 3, no overflow, next pass starts after one IDLE cycle.
REQ-038 SHALL check: rst pulse at col=4 -> outputs 0 asynchronously before the next edge; no win_valid until 3 new row_done pulses.
